// File: rtl/tdl_link_manager.sv
`default_nettype none
// ============================================================================
//  Module   : tdl_link_manager
//  Purpose  : Brings up, qualifies and supervises the TDL receive link.
//             Sequences the RX datapath reset, waits for reset-done and
//             comma alignment, qualifies alignment, filters short alignment
//             drops, and retries a bounded number of times before faulting.
//  Revision : 1.0  initial release
// ============================================================================
module tdl_link_manager #(
  parameter int unsigned RESET_PULSE    = 16,
  parameter int unsigned DONE_TIMEOUT   = 1000000,
  parameter int unsigned ALIGN_TIMEOUT  = 1000000,
  parameter int unsigned QUALIFY_CYCLES = 65536,
  parameter int unsigned LOSS_FILTER    = 64,
  parameter int unsigned MAX_RETRIES    = 8,
  parameter int unsigned TIMER_W        = 24
) (
  input  logic       clk_freerun,
  input  logic       reset_n,
  input  logic       qpll0lock_in,
  input  logic       reset_rx_done_in,
  input  logic       rxaligned_in,
  input  logic       relink_req_in,
  output logic       reset_rx_datapath_out,
  output logic       link_up_out,
  output logic       link_fault_out,
  output logic [7:0] retry_cnt_out,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RST        = 3'd1,
    ST_WAIT_DONE  = 3'd2,
    ST_WAIT_ALIGN = 3'd3,
    ST_QUALIFY    = 3'd4,
    ST_UP         = 3'd5,
    ST_LOSS       = 3'd6,
    ST_FAULT      = 3'd7
  } state_t;

  // Terminal timer values: the timer starts at 0 on state entry, so the last
  // cycle of an N-cycle window is N-1.
  localparam logic [TIMER_W-1:0] RST_LAST   = TIMER_W'(RESET_PULSE - 1);
  localparam logic [TIMER_W-1:0] DONE_LAST  = TIMER_W'(DONE_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] ALIGN_LAST = TIMER_W'(ALIGN_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] QUAL_LAST  = TIMER_W'(QUALIFY_CYCLES - 1);
  // The unaligned cycle seen in UP counts towards the loss filter, so LOSS
  // itself only has to observe LOSS_FILTER-1 further unaligned cycles.
  localparam logic [TIMER_W-1:0] LOSS_LAST  =
      TIMER_W'((LOSS_FILTER >= 2) ? (LOSS_FILTER - 2) : 0);

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [7:0]           retry_q, retry_d;
  logic [2:0]           meta_q, meta_d, sync_q, sync_d;
  logic                 rst_out_q, rst_out_d;
  logic                 link_up_q, link_up_d;
  logic                 fault_q, fault_d;
  logic                 qlock, done, aligned;
  logic                 fail_attempt;
  logic [7:0]           retry_inc;

  assign qlock   = sync_q[2];
  assign done    = sync_q[1];
  assign aligned = sync_q[0];

  // Two-flop synchronizer inputs for the asynchronous status lines
  always_comb begin
    meta_d = {qpll0lock_in, reset_rx_done_in, rxaligned_in};
    sync_d = meta_q;
  end

  // Next-state, retry accounting and attempt-failure decisions
  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    fail_attempt = 1'b0;
    retry_inc    = (retry_q == 8'hFF) ? 8'hFF : retry_q + 8'd1;

    case (state_q)
      ST_IDLE:       if (qlock) state_d = ST_RST;
      ST_RST:        if (timer_q == RST_LAST) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (done)                       state_d = ST_WAIT_ALIGN;
        else if (timer_q == DONE_LAST)  fail_attempt = 1'b1;
      end
      ST_WAIT_ALIGN: begin
        if (aligned)                    state_d = ST_QUALIFY;
        else if (timer_q == ALIGN_LAST) fail_attempt = 1'b1;
      end
      ST_QUALIFY: begin
        if (!aligned) begin
          fail_attempt = 1'b1;
        end else if (timer_q == QUAL_LAST) begin
          state_d = ST_UP;
          retry_d = 8'd0;
        end
      end
      ST_UP:         if (!aligned) state_d = ST_LOSS;
      ST_LOSS: begin
        if (aligned)                    state_d = ST_UP;
        else if (timer_q >= LOSS_LAST)  fail_attempt = 1'b1;
      end
      ST_FAULT:      state_d = ST_FAULT;
      default:       state_d = ST_IDLE;
    endcase

    if (fail_attempt) begin
      retry_d = retry_inc;
      state_d = (32'(retry_inc) >= MAX_RETRIES) ? ST_FAULT : ST_RST;
    end

    // A relink request overrides everything; losing the PLL lock overrides
    // the normal flow but is not an attempt failure, so the count is kept.
    if (relink_req_in) begin
      state_d = ST_RST;
      retry_d = 8'd0;
    end else if (!qlock && state_q != ST_IDLE && state_q != ST_FAULT) begin
      state_d = ST_IDLE;
      retry_d = retry_q;
    end
  end

  // Timer restarts on every state change (and on relink); saturates otherwise
  always_comb begin
    if (state_d != state_q || relink_req_in) begin
      timer_d = '0;
    end else if (timer_q == '1) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  // Registered outputs are decoded from the next state so they track state_q
  always_comb begin
    rst_out_d = (state_d == ST_RST);
    link_up_d = (state_d inside {ST_UP, ST_LOSS});
    fault_d   = (state_d == ST_FAULT);
  end

  // State, timer, synchronizer and output registers
  always_ff @(posedge clk_freerun or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      retry_q   <= 8'd0;
      meta_q    <= 3'b000;
      sync_q    <= 3'b000;
      rst_out_q <= 1'b0;
      link_up_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      rst_out_q <= rst_out_d;
      link_up_q <= link_up_d;
      fault_q   <= fault_d;
    end
  end

  assign reset_rx_datapath_out = rst_out_q;
  assign link_up_out           = link_up_q;
  assign link_fault_out        = fault_q;
  assign retry_cnt_out         = retry_q;
  assign state_out             = state_q;

endmodule
`default_nettype wire

// File: tb/tb_tdl_link_manager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdl_link_manager
//  Purpose  : Self-checking bench for tdl_link_manager. Scenario timing is
//             randomized; expectations come from a small arithmetic model of
//             the link rules (sync latency, window lengths, retry budget).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdl_link_manager;

  localparam int RESET_PULSE    = 16;
  localparam int DONE_TIMEOUT   = 1000;
  localparam int ALIGN_TIMEOUT  = 600;
  localparam int QUALIFY_CYCLES = 300;
  localparam int LOSS_FILTER    = 64;
  localparam int MAX_RETRIES    = 8;
  localparam int TIMER_W        = 16;

  // Model constants: a port change made after edge k is synced by edge k+2
  // and acted upon at edge k+3.
  localparam int SYNC_LAT  = 2;
  localparam int REACT_LAT = SYNC_LAT + 1;

  logic       clk_freerun = 1'b0;
  logic       reset_n;
  logic       qpll0lock_in;
  logic       reset_rx_done_in;
  logic       rxaligned_in;
  logic       relink_req_in;
  logic       reset_rx_datapath_out;
  logic       link_up_out;
  logic       link_fault_out;
  logic [7:0] retry_cnt_out;
  logic [2:0] state_out;

  int n_checks = 0;
  int n_errors = 0;
  int exp_retry = 0;

  tdl_link_manager #(
    .RESET_PULSE    (RESET_PULSE),
    .DONE_TIMEOUT   (DONE_TIMEOUT),
    .ALIGN_TIMEOUT  (ALIGN_TIMEOUT),
    .QUALIFY_CYCLES (QUALIFY_CYCLES),
    .LOSS_FILTER    (LOSS_FILTER),
    .MAX_RETRIES    (MAX_RETRIES),
    .TIMER_W        (TIMER_W)
  ) dut (
    .clk_freerun           (clk_freerun),
    .reset_n               (reset_n),
    .qpll0lock_in          (qpll0lock_in),
    .reset_rx_done_in      (reset_rx_done_in),
    .rxaligned_in          (rxaligned_in),
    .relink_req_in         (relink_req_in),
    .reset_rx_datapath_out (reset_rx_datapath_out),
    .link_up_out           (link_up_out),
    .link_fault_out        (link_fault_out),
    .retry_cnt_out         (retry_cnt_out),
    .state_out             (state_out)
  );

  always #5 clk_freerun = ~clk_freerun;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model pieces
  function automatic int model_qualify_latency();
    return QUALIFY_CYCLES + REACT_LAT;  // port edge -> link_up visible
  endfunction

  function automatic bit model_drop_survives(input int len);
    return len < LOSS_FILTER;           // fewer than LOSS_FILTER unaligned cycles
  endfunction

  function automatic int model_retry_after_fail(input int r);
    return (r >= 255) ? 255 : r + 1;
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: advance to just after the next rising edge
  task automatic step();
    @(posedge clk_freerun);
    #1;
  endtask

  task automatic wait_state(input string tag, input int st, input int budget);
    int n = 0;
    while (int'(state_out) != st && n < budget) begin
      step();
      n++;
    end
    check_val(tag, int'(state_out), st);
  endtask

  task automatic wait_link_up(input string tag, input int budget);
    int n = 0;
    while (link_up_out !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check_val(tag, int'(link_up_out), 1);
  endtask

  // Wait for a reset pulse and return how many samples it stayed high
  task automatic measure_pulse(input string tag, input int budget, output int width);
    int n = 0;
    width = 0;
    while (reset_rx_datapath_out !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check_val({tag, "_seen"}, int'(reset_rx_datapath_out), 1);
    while (reset_rx_datapath_out === 1'b1 && width < 1000) begin
      width++;
      step();
    end
  endtask

  // Drop rxaligned for len cycles while UP and check the filter outcome
  task automatic glitch(input int len);
    bit survive = model_drop_survives(len);
    int first_down = -1;
    int st_down = -1;
    int retry_down = -1;
    int rst_samples = 0;
    int total = len + LOSS_FILTER + 4;
    rxaligned_in = 1'b0;
    for (int i = 1; i <= total; i++) begin
      step();
      if (link_up_out !== 1'b1 && first_down < 0) begin
        first_down = i;
        st_down    = int'(state_out);
        retry_down = int'(retry_cnt_out);
      end
      if (reset_rx_datapath_out === 1'b1) rst_samples++;
      if (i == len) rxaligned_in = 1'b1;
    end
    if (survive) begin
      check_val($sformatf("glitch%0d_link_held", len), first_down, -1);
      check_val($sformatf("glitch%0d_no_pulse", len), rst_samples, 0);
      check_val($sformatf("glitch%0d_state", len), int'(state_out), 5);
    end else begin
      exp_retry = model_retry_after_fail(exp_retry);
      check_val($sformatf("loss%0d_down_cycle", len), first_down, LOSS_FILTER + SYNC_LAT);
      check_val($sformatf("loss%0d_state", len), st_down, 1);
      check_val($sformatf("loss%0d_retry", len), retry_down, exp_retry);
      check_val($sformatf("loss%0d_pulse_w", len), rst_samples, RESET_PULSE);
      wait_link_up($sformatf("loss%0d_relink", len), 2000);
      exp_retry = 0;
      check_val($sformatf("loss%0d_retry_clr", len), int'(retry_cnt_out), exp_retry);
    end
  endtask

  initial begin
    int w, d, lat, n, up_seen, pulses, first_rise, second_rise;
    logic prev_rst;

    reset_n = 1'b0; qpll0lock_in = 1'b1; reset_rx_done_in = 1'b0;
    rxaligned_in = 1'b0; relink_req_in = 1'b0;
    repeat (5) step();
    check_val("rst_state", int'(state_out), 0);
    check_val("rst_pulse_out", int'(reset_rx_datapath_out), 0);
    check_val("rst_link_up", int'(link_up_out), 0);
    check_val("rst_fault", int'(link_fault_out), 0);
    check_val("rst_retry", int'(retry_cnt_out), 0);

    // Bring-up
    reset_n = 1'b1;
    measure_pulse("bringup_pulse", 50, w);
    check_val("bringup_pulse_w", w, RESET_PULSE);
    check_val("bringup_wait_done", int'(state_out), 2);
    d = int'($urandom_range(20, 200));
    repeat (d) step();
    reset_rx_done_in = 1'b1;
    repeat (REACT_LAT - 1) step();
    check_val("done_not_yet", int'(state_out), 2);
    step();
    check_val("done_to_align", int'(state_out), 3);
    d = int'($urandom_range(10, 100));
    repeat (d) step();
    rxaligned_in = 1'b1;
    lat = 0;
    while (link_up_out !== 1'b1 && lat < QUALIFY_CYCLES + 50) begin
      step();
      lat++;
    end
    check_val("qualify_latency", lat, model_qualify_latency());
    check_val("bringup_state", int'(state_out), 5);
    check_val("bringup_retry", int'(retry_cnt_out), exp_retry);

    // Alignment drops: short ones are filtered, long ones force a retry
    glitch(40);
    glitch(LOSS_FILTER - 1);
    glitch(int'($urandom_range(1, LOSS_FILTER - 1)));
    glitch(LOSS_FILTER);
    glitch(int'($urandom_range(LOSS_FILTER, LOSS_FILTER + 30)));

    // Qualify abort via a fresh relink attempt
    relink_req_in = 1'b1;
    step();
    relink_req_in = 1'b0;
    exp_retry = 0;
    check_val("relink_state", int'(state_out), 1);
    check_val("relink_link_up", int'(link_up_out), 0);
    up_seen = 0;
    n = 0;
    while (int'(state_out) != 4 && n < 300) begin
      step();
      n++;
      if (link_up_out === 1'b1) up_seen++;
    end
    check_val("qabort_in_qualify", int'(state_out), 4);
    d = int'($urandom_range(50, QUALIFY_CYCLES - 50));
    for (int i = 0; i < d; i++) begin
      step();
      if (link_up_out === 1'b1) up_seen++;
    end
    rxaligned_in = 1'b0;
    repeat (REACT_LAT - 1) step();
    check_val("qabort_still_qualify", int'(state_out), 4);
    step();
    exp_retry = model_retry_after_fail(exp_retry);
    check_val("qabort_state", int'(state_out), 1);
    check_val("qabort_retry", int'(retry_cnt_out), exp_retry);
    check_val("qabort_never_up", up_seen + int'(link_up_out), 0);

    // Lock loss outside UP keeps the retry count
    wait_state("lockloss_wait_align", 3, 300);
    qpll0lock_in = 1'b0;
    repeat (REACT_LAT) step();
    check_val("lockloss_wa_state", int'(state_out), 0);
    check_val("lockloss_wa_retry", int'(retry_cnt_out), exp_retry);
    qpll0lock_in = 1'b1;
    rxaligned_in = 1'b1;
    wait_link_up("relock_up", 2000);
    exp_retry = 0;

    // Lock loss in UP
    qpll0lock_in = 1'b0;
    repeat (REACT_LAT - 1) step();
    check_val("lockloss_up_held", int'(link_up_out), 1);
    step();
    check_val("lockloss_up_state", int'(state_out), 0);
    check_val("lockloss_up_link", int'(link_up_out), 0);
    check_val("lockloss_up_retry", int'(retry_cnt_out), exp_retry);

    // Retry exhaustion: reset-done never arrives
    reset_rx_done_in = 1'b0;
    rxaligned_in     = 1'b0;
    qpll0lock_in     = 1'b1;
    pulses = 0; first_rise = -1; second_rise = -1;
    prev_rst = 1'b0;
    for (int i = 0; i < (MAX_RETRIES + 1) * (RESET_PULSE + DONE_TIMEOUT); i++) begin
      step();
      if (reset_rx_datapath_out === 1'b1 && prev_rst === 1'b0) begin
        pulses++;
        if (first_rise < 0) first_rise = i;
        else if (second_rise < 0) second_rise = i;
      end
      prev_rst = reset_rx_datapath_out;
    end
    check_val("exhaust_pulses", pulses, MAX_RETRIES);
    check_val("exhaust_spacing", second_rise - first_rise, RESET_PULSE + DONE_TIMEOUT);
    check_val("exhaust_state", int'(state_out), 7);
    check_val("exhaust_fault", int'(link_fault_out), 1);
    check_val("exhaust_retry", int'(retry_cnt_out), MAX_RETRIES);
    check_val("exhaust_no_pulse", int'(reset_rx_datapath_out), 0);

    // Fault recovery
    relink_req_in = 1'b1;
    step();
    relink_req_in = 1'b0;
    check_val("recover_state", int'(state_out), 1);
    check_val("recover_fault", int'(link_fault_out), 0);
    check_val("recover_retry", int'(retry_cnt_out), 0);
    check_val("recover_pulse", int'(reset_rx_datapath_out), 1);

    // Asynchronous reset in the middle of RST
    repeat (5) step();
    check_val("mid_rst_pulse", int'(reset_rx_datapath_out), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_pulse", int'(reset_rx_datapath_out), 0);
    check_val("async_state", int'(state_out), 0);
    check_val("async_link_up", int'(link_up_out), 0);
    check_val("async_fault", int'(link_fault_out), 0);
    check_val("async_retry", int'(retry_cnt_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
